// File: rtl/stream_pkg.sv
// Shared helpers for the stream blocks: pointer and occupancy width rules.
package stream_pkg;

  // A pointer is never narrower than one bit, even for degenerate depths.
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < n) r = r + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

  // Occupancy must represent 0..DEPTH inclusive, hence one bit above the pointer width.
  function automatic int count_width(input int depth);
    return clog2_min1(depth) + 1;
  endfunction

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_DEPTH = 8;

endpackage

// File: rtl/stream_fifo_mem.sv
// DEPTH x WIDTH register array: synchronous write, asynchronous read, contents never reset.
module stream_fifo_mem
  import stream_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int PTR_W = clog2_min1(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [PTR_W-1:0] waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [PTR_W-1:0] raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/stream_credit_fifo.sv
// Elastic FWFT FIFO behind a non-stalling delay stage; ready_i reserves SLACK slots
// for beats still in flight so a well-behaved upstream never loses data.
module stream_credit_fifo
  import stream_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int SLACK = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [WIDTH-1:0]             data_i,
  input  logic                         valid_i,
  output logic                         ready_i,
  output logic [WIDTH-1:0]             data_o,
  output logic                         valid_o,
  input  logic                         ready_o,
  output logic [count_width(DEPTH)-1:0] count,
  output logic                         overflow
);

  localparam int PTR_W = clog2_min1(DEPTH);
  localparam int CNT_W = count_width(DEPTH);
  localparam int SUM_W = CNT_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;

  logic push, pop, drop;

  // Control uses only valid_i/ready_o so unknown payload bits never reach state.
  always_comb begin
    pop  = valid_o & ready_o;
    push = valid_i & ((count_q < DEPTH_C) | pop);
    drop = valid_i & ~push;

    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q | drop;

    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);

    if (push && !pop)      count_d = count_q + CNT_W'(1);
    else if (pop && !push) count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  stream_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr_q),
    .wdata (data_i),
    .raddr (rd_ptr_q),
    .rdata (data_o)
  );

  // Widened by one bit so count + SLACK cannot wrap.
  always_comb begin
    ready_i = ({1'b0, count_q} + SUM_W'(SLACK)) < SUM_W'(DEPTH);
    valid_o = (count_q != '0);
  end

  assign count    = count_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_stream_credit_fifo.sv
// Scoreboard bench for stream_credit_fifo (DEPTH=8, SLACK=2): a queue model predicts
// every output each cycle, plus directed checks for latency, slack, full and reset cases.
module tb_stream_credit_fifo;

  localparam int WIDTH = 32;
  localparam int DEPTH = 8;
  localparam int SLACK = 2;

  logic              clk;
  logic              reset;
  logic [WIDTH-1:0]  data_i;
  logic              valid_i;
  logic              ready_i;
  logic [WIDTH-1:0]  data_o;
  logic              valid_o;
  logic              ready_o;
  logic [3:0]        count;
  logic              overflow;

  int checks;
  int errors;
  int max_count;

  logic [WIDTH-1:0] sb[$];
  logic             model_ovf;

  stream_credit_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .SLACK (SLACK)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .data_i   (data_i),
    .valid_i  (valid_i),
    .ready_i  (ready_i),
    .data_o   (data_o),
    .valid_o  (valid_o),
    .ready_o  (ready_o),
    .count    (count),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Inputs change just after a rising edge and hold for one full cycle.
  task automatic applyStimulus(input logic v, input logic [WIDTH-1:0] d, input logic r);
    valid_i = v;
    data_i  = d;
    ready_o = r;
    @(posedge clk);
    #1;
  endtask

  // Mid-cycle model: compare everything against the queue, then advance it as the edge will.
  always @(negedge clk) begin
    if (reset) begin
      sb.delete();
      model_ovf = 1'b0;
    end else begin
      logic m_pop, m_push;
      m_pop = (sb.size() != 0) && ready_o;
      checkOutput("sb_valid_o", {31'b0, valid_o}, {31'b0, sb.size() != 0});
      checkOutput("sb_count", {28'b0, count}, sb.size());
      checkOutput("sb_ready_i", {31'b0, ready_i}, {31'b0, (sb.size() + SLACK) < DEPTH});
      checkOutput("sb_overflow", {31'b0, overflow}, {31'b0, model_ovf});
      if (m_pop) begin
        checkOutput("sb_data_o", data_o, sb[0]);
        void'(sb.pop_front());
      end
      m_push = valid_i && ((sb.size() < DEPTH) || m_pop);
      if (m_push) sb.push_back(data_i);
      if (valid_i && !m_push) model_ovf = 1'b1;
      if (int'(count) > max_count) max_count = int'(count);
    end
  end

  initial begin
    int d;
    int sent;
    int cyc;
    logic fell;
    logic pattern [5];

    checks    = 0;
    errors    = 0;
    max_count = 0;
    model_ovf = 1'b0;
    pattern   = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    reset     = 1'b1;
    valid_i   = 1'b0;
    data_i    = '0;
    ready_o   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_count", {28'b0, count}, 0);
    checkOutput("rst_valid_o", {31'b0, valid_o}, 0);
    checkOutput("rst_ready_i", {31'b0, ready_i}, 1);
    checkOutput("rst_overflow", {31'b0, overflow}, 0);
    reset = 1'b0;

    // One-cycle latency through an empty FIFO.
    applyStimulus(1'b1, 32'hA5, 1'b1);
    checkOutput("lat_valid_o", {31'b0, valid_o}, 1);
    checkOutput("lat_data_o", data_o, 32'hA5);
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("lat_empty_valid", {31'b0, valid_o}, 0);
    checkOutput("lat_empty_count", {28'b0, count}, 0);

    // Fill with a stalled consumer; upstream stops on ready_i but SLACK beats still land.
    d = 1;
    fell = 1'b0;
    for (int i = 0; i < 20 && !fell; i++) begin
      applyStimulus(1'b1, d, 1'b0);
      d++;
      if (!ready_i) begin
        fell = 1'b1;
        checkOutput("fill_fall_count", {28'b0, count}, 6);
      end
    end
    checkOutput("fill_ready_fell", {31'b0, fell}, 1);
    for (int i = 0; i < SLACK; i++) begin
      applyStimulus(1'b1, d, 1'b0);
      d++;
    end
    checkOutput("fill_count", {28'b0, count}, 8);
    checkOutput("fill_overflow", {31'b0, overflow}, 0);
    checkOutput("fill_ready_i", {31'b0, ready_i}, 0);

    // Push and pop together while full: no loss, count stays at DEPTH.
    applyStimulus(1'b1, 32'h99, 1'b1);
    checkOutput("full_pp_count", {28'b0, count}, 8);
    checkOutput("full_pp_overflow", {31'b0, overflow}, 0);
    checkOutput("full_pp_head", data_o, 2);

    // Push into a full FIFO with no pop is dropped and sets the sticky flag.
    applyStimulus(1'b1, 32'hEE, 1'b0);
    checkOutput("drop_overflow", {31'b0, overflow}, 1);
    checkOutput("drop_count", {28'b0, count}, 8);
    repeat (8) applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("drain_count", {28'b0, count}, 0);
    checkOutput("drain_overflow_sticky", {31'b0, overflow}, 1);

    // Wrap-around with an irregular consumer; upstream honours ready_i.
    sent = 0;
    max_count = 0;
    for (cyc = 0; sent < 20 && cyc < 200; cyc++) begin
      if (ready_i) begin
        applyStimulus(1'b1, sent, pattern[cyc % 5]);
        sent++;
      end else begin
        applyStimulus(1'b0, 32'h0, pattern[cyc % 5]);
      end
    end
    checkOutput("wrap_all_sent", sent, 20);
    for (int i = 0; i < 100 && count != 0; i++) begin
      applyStimulus(1'b0, 32'h0, pattern[cyc % 5]);
      cyc++;
    end
    checkOutput("wrap_drained", {28'b0, count}, 0);
    checkOutput("wrap_max_le_depth", {31'b0, max_count <= DEPTH}, 1);

    // Asynchronous reset between clock edges with five beats buffered.
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 32'h50 + i, 1'b0);
    checkOutput("pre_rst_count", {28'b0, count}, 5);
    valid_i = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    checkOutput("async_rst_valid_o", {31'b0, valid_o}, 0);
    checkOutput("async_rst_count", {28'b0, count}, 0);
    checkOutput("async_rst_ready_i", {31'b0, ready_i}, 1);
    checkOutput("async_rst_overflow", {31'b0, overflow}, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    applyStimulus(1'b1, 32'h3C, 1'b1);
    checkOutput("post_rst_valid_o", {31'b0, valid_o}, 1);
    checkOutput("post_rst_data_o", data_o, 32'h3C);
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("post_rst_count", {28'b0, count}, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/stream_credit_fifo.md
Name: stream_credit_fifo

Overview:
- Elastic FIFO that sits directly downstream of the fixed-latency stream delay stage.
- The delay stage does not stall on backpressure: beats already in flight keep arriving after downstream ready drops. This block absorbs those beats.
- It drives the upstream ready early enough, using a SLACK margin, that no in-flight beat is lost.
- Toward its consumer it presents a standard first-word-fall-through valid/ready stream.

Parameters:
- WIDTH, 32, payload width in bits.
- DEPTH, 8, storage entries; power of two, >= 2.
- SLACK, 1, beats that can still arrive after ready_i deasserts (the upstream delay N); 0 <= SLACK < DEPTH.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- data_i  in  WIDTH  input payload.
- valid_i  in  1  input beat present. Sampled every cycle regardless of ready_i.
- ready_i  out  1  credit to upstream: may send.
- data_o  out  WIDTH  head-of-FIFO payload.
- valid_o  out  1  FIFO non-empty.
- ready_o  in  1  consumer accepts head.
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky: a beat was dropped.

Behaviour:
- Reset, asynchronous assert: count=0, read/write pointers=0, overflow=0, valid_o=0, ready_i=1 (combinational from count).
- Deassertion is synchronised externally; the block has no reset synchroniser.
- Storage contents are not reset; data_o is don't-care while valid_o=0.
- pop = valid_o & ready_o.
- push = valid_i & (count < DEPTH | pop).
  - The input is accepted whenever there is space or a simultaneous pop frees a slot.
  - ready_i does NOT gate push, because upstream ignores backpressure.
- drop = valid_i & ~push.
  - On drop, overflow <= 1 and stays 1 until reset.
  - Storage, pointers and count are unchanged on a drop.
- Occupancy update:
  - push & ~pop: count+1.
  - pop & ~push: count-1.
  - both, or neither: count unchanged.
- Simultaneous push and pop:
  - Legal at any occupancy except empty.
  - When full: the pop frees the slot and the push writes it in the same cycle; count stays DEPTH.
  - When empty: no bypass path. valid_o is 0, so pop=0 and the beat is written. valid_o rises the next cycle.
- Latency, empty to output: beat on valid_i in cycle t appears on data_o/valid_o in cycle t+1 (one-cycle minimum latency).
- FWFT: data_o = mem[rd_ptr] whenever valid_o=1. data_o and valid_o stay stable while valid_o & ~ready_o.
- Pointers: $clog2(DEPTH) bits each, wrap modulo DEPTH naturally. Full/empty is decided by count, not by pointer comparison.
- ready_i = (count + SLACK) < DEPTH, combinational from registered count.
  - Guarantee: if upstream honours ready_i and has at most SLACK beats in flight, drop never occurs.
  - Compute at width $clog2(DEPTH)+2 so the sum does not overflow.
- valid_o = (count != 0).
- Reset mid-operation: all buffered beats are discarded; outputs return to reset values asynchronously.
- No X propagation: push, pop and drop are computed with valid_i and ready_o only; data_i is never used in control logic.

Decomposition:
- Shared package stream_pkg:
  - function clog2_min1(n), returning at least 1, used for pointer widths.
  - localparam convention for count width: clog2(DEPTH)+1.
- Sub-module stream_fifo_mem:
  - DEPTH x WIDTH register array.
  - Synchronous write port (we, waddr, wdata) and asynchronous read port (raddr, rdata).
  - No reset on contents.
- stream_credit_fifo holds pointers, count, overflow and the handshake logic.

Test Plan:
- Reset, then one beat valid_i=1, data_i=0xA5 at cycle 0 with ready_o=1 -> cycle 1: valid_o=1, data_o=0xA5; cycle 2: valid_o=0, count=0.
- DEPTH=8, SLACK=2, ready_o=0, one beat per cycle with data 1,2,3,... ->
  - ready_i falls when count=6.
  - Upstream stops; 2 in-flight beats land; count=8, overflow=0.
  - Then raise ready_o -> data_o sequence 1..8 in order, no gaps.
- Full FIFO (count=8), valid_i=1, ready_o=1 same cycle, data 0x99 -> count stays 8, overflow=0, 0x99 emerges after the 7 older beats.
- Full FIFO, valid_i=1, ready_o=0 -> overflow=1 next cycle, count=8. Drain shows the original 8 beats only. overflow stays 1 until reset.
- Wrap-around: stream 20 beats (0..19) with ready_o toggling 1,0,1,1,0 repeating -> output exactly 0..19 in order; count never exceeds 8.
- Assert reset asynchronously mid-stream with count=5, between clock edges -> valid_o=0, count=0, ready_i=1 immediately. After release, a new beat 0x3C is output one cycle after entry.
